// File: rtl/commit_trace_emitter_pkg.sv
// Shared definitions for the commit trace writer: record field layout and FSM states.
// Record = {seq, pc, inst, we, waddr, wdata}; width is REC_BASE_W + sequence counter width.
package commit_trace_emitter_pkg;

  localparam int PC_W       = 32;
  localparam int INST_W     = 32;
  localparam int ADDR_W     = 5;
  localparam int DATA_W     = 32;

  localparam int WDATA_LSB  = 0;
  localparam int WADDR_LSB  = WDATA_LSB + DATA_W;
  localparam int WE_BIT     = WADDR_LSB + ADDR_W;
  localparam int INST_LSB   = WE_BIT + 1;
  localparam int PC_LSB     = INST_LSB + INST_W;
  localparam int SEQ_LSB    = PC_LSB + PC_W;
  localparam int REC_BASE_W = SEQ_LSB;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_LIMIT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/commit_trace_emitter_fifo.sv
// First-word-fall-through FIFO of packed trace records; 1-cycle push-to-head latency.
// Caller must not push when full unless popping the same cycle; dout reads 0 while empty.
module commit_trace_emitter_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 118
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_ptr_q, rd_ptr_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

  // Storage needs no reset: the pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign dout  = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/commit_trace_emitter.sv
// Retired-instruction trace writer: records each WB commit into a FIFO on a valid/ready stream.
// Optional macro TRACE_DEDUP_EN suppresses a push whose pc repeats the last accepted record.
module commit_trace_emitter
  import commit_trace_emitter_pkg::*;
#(
  parameter int DEPTH       = 8,
  parameter int CNT_W       = 16,
  parameter int MAX_RECORDS = 5000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wb_valid,
  input  logic [31:0]      wb_pc,
  input  logic [31:0]      wb_inst,
  input  logic             wb_we,
  input  logic [4:0]       wb_waddr,
  input  logic [31:0]      wb_wdata,
  input  logic             tr_ready,
  output logic             tr_valid,
  output logic [31:0]      tr_pc,
  output logic [31:0]      tr_inst,
  output logic             tr_we,
  output logic [4:0]       tr_waddr,
  output logic [31:0]      tr_wdata,
  output logic [CNT_W-1:0] tr_seq,
  output logic             overflow,
  output logic [CNT_W-1:0] drop_cnt,
  output logic             done
);

  localparam int REC_W = REC_BASE_W + CNT_W;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] seq_q, seq_d;
  logic [CNT_W-1:0] drop_q, drop_d;
  logic             ovf_q, ovf_d;
  logic [31:0]      acc_q, acc_d;
  logic             fifo_full, fifo_empty, pop, push_req, accept, dup;
  logic [REC_W-1:0] fifo_din, fifo_dout;

`ifdef TRACE_DEDUP_EN
  logic [31:0] last_pc_q;
  logic        last_vld_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_pc_q  <= '0;
      last_vld_q <= 1'b0;
    end else if (accept) begin
      last_pc_q  <= wb_pc;
      last_vld_q <= 1'b1;
    end
  end

  assign dup = last_vld_q && (wb_pc == last_pc_q);
`else
  assign dup = 1'b0;
`endif

  assign pop      = !fifo_empty && tr_ready;
  assign push_req = wb_valid && (state_q == ST_RUN) && !dup;
  // A full FIFO can still take a record when the head leaves on the same edge.
  assign accept   = push_req && (!fifo_full || pop);
  assign fifo_din = {seq_q, wb_pc, wb_inst, wb_we, wb_waddr, wb_wdata};

  always_comb begin
    state_d = state_q;
    seq_d   = seq_q;
    drop_d  = drop_q;
    ovf_d   = ovf_q;
    acc_d   = acc_q;
    case (state_q)
      ST_RUN: begin
        if (accept) begin
          seq_d = seq_q + CNT_W'(1);
          acc_d = acc_q + 32'd1;
          if ((MAX_RECORDS != 0) && (acc_q + 32'd1 == 32'(MAX_RECORDS))) state_d = ST_LIMIT;
        end else if (push_req) begin
          ovf_d = 1'b1;
          if (drop_q != '1) drop_d = drop_q + CNT_W'(1);
        end
      end
      ST_LIMIT: if (fifo_empty) state_d = ST_DONE;
      ST_DONE:  state_d = ST_DONE;
      default:  state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_RUN;
      seq_q   <= '0;
      drop_q  <= '0;
      ovf_q   <= 1'b0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      seq_q   <= seq_d;
      drop_q  <= drop_d;
      ovf_q   <= ovf_d;
      acc_q   <= acc_d;
    end
  end

  commit_trace_emitter_fifo #(.DEPTH(DEPTH), .W(REC_W)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (accept),
    .din   (fifo_din),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign tr_valid = !fifo_empty;
  assign tr_seq   = fifo_dout[SEQ_LSB +: CNT_W];
  assign tr_pc    = fifo_dout[PC_LSB +: PC_W];
  assign tr_inst  = fifo_dout[INST_LSB +: INST_W];
  assign tr_we    = fifo_dout[WE_BIT];
  assign tr_waddr = fifo_dout[WADDR_LSB +: ADDR_W];
  assign tr_wdata = fifo_dout[WDATA_LSB +: DATA_W];
  assign overflow = ovf_q;
  assign drop_cnt = drop_q;
  assign done     = (state_q == ST_DONE);

endmodule
